// File: rtl/cmp_rgb_led_ctrl_pkg.sv
// Shared types and the LED mapping for the RGB status comparator.
package cmp_led_pkg;

  // IDLE: no result yet | CMP: operands latched | HOLD: result held
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_res_t;

  // Base LED colours {red, green, blue}; dark until a first result exists.
  function automatic logic [2:0] led_map(input cmp_res_t res, input logic valid);
    logic [2:0] rgb;
    rgb[2] = res.gt | res.eq;
    rgb[1] = res.lt | res.eq;
    rgb[0] = ~res.eq;
    return valid ? rgb : 3'b000;
  endfunction

endpackage

// File: rtl/cmp_rgb_led_ctrl_pwm.sv
// PWM dimmer: free-running counter, period-aligned duty capture, 3-channel gate.
module rgb_pwm_gen #(
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] duty,
  input  logic [2:0]          base,
  output logic [2:0]          led
);

  logic [PWM_BITS-1:0] cnt_q;
  logic [PWM_BITS-1:0] duty_q;
  logic [PWM_BITS-1:0] duty_d;
  logic [2:0]          led_q;
  logic                pwm_on;

  // Duty is only sampled at the start of a period so a period is never cut short.
  assign duty_d = (cnt_q == '0) ? duty : duty_q;
  assign pwm_on = (cnt_q < duty_q);

  // Counter wraps naturally at 2**PWM_BITS; duty register follows its capture rule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      duty_q <= '0;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
      duty_q <= duty_d;
    end
  end

  // Registered LED drives keep the pins glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= 3'b000;
    end else begin
      led_q <= base & {3{pwm_on}};
    end
  end

  assign led = led_q;

endmodule

// File: rtl/cmp_rgb_led_ctrl.sv
// Registered signed/unsigned magnitude comparator with PWM-dimmed RGB status LED.
module cmp_rgb_led_ctrl
  import cmp_led_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic                signed_mode,
  input  logic [PWM_BITS-1:0] duty,
  output logic                res_valid,
  output logic                gt,
  output logic                eq,
  output logic                lt,
  output logic                red,
  output logic                green,
  output logic                blue
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sm_q;
  cmp_res_t         res_q, res_d;
  logic             has_res_q;
  logic             res_valid_q;
  logic             accept;
  logic [WIDTH:0]   a_ext, b_ext, diff;
  logic [2:0]       base;
  logic [2:0]       led;

  assign in_ready = (state_q != CMP);
  assign accept   = in_valid && in_ready;

  // Next-state logic: one compare cycle per accepted pair, then hold the result.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, HOLD: if (accept) state_d = CMP;
      CMP:        state_d = HOLD;
      default:    state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture on accept; nothing presented during CMP is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      sm_q <= 1'b0;
    end else if (accept) begin
      a_q  <= a;
      b_q  <= b;
      sm_q <= signed_mode;
    end
  end

  // One extra bit makes the difference of two extended operands overflow-free,
  // so its MSB is the true sign for both signed and unsigned compares.
  always_comb begin
    a_ext    = sm_q ? {a_q[WIDTH-1], a_q} : {1'b0, a_q};
    b_ext    = sm_q ? {b_q[WIDTH-1], b_q} : {1'b0, b_q};
    diff     = a_ext - b_ext;
    res_d.eq = (diff == '0);
    res_d.lt = diff[WIDTH];
    res_d.gt = ~diff[WIDTH] & (diff != '0);
  end

  // Flags update only when leaving CMP; res_valid pulses for exactly that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q       <= '0;
      has_res_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      res_valid_q <= (state_q == CMP);
      if (state_q == CMP) begin
        res_q     <= res_d;
        has_res_q <= 1'b1;
      end
    end
  end

  assign res_valid = res_valid_q;
  assign gt        = res_q.gt;
  assign eq        = res_q.eq;
  assign lt        = res_q.lt;
  assign base      = led_map(res_q, has_res_q);

  rgb_pwm_gen #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clk  (clk),
    .rst_n(rst_n),
    .duty (duty),
    .base (base),
    .led  (led)
  );

  assign red   = led[2];
  assign green = led[1];
  assign blue  = led[0];

endmodule
